hyperbus_mem_slave: RTL



---
 rtl/hyperbus_mem_slave.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_mem_slave.sv
// hyperbus_mem_slave
//   Behavioural-synthesisable HyperBus memory slave. It decodes the 48-bit
//   command-address, waits a configurable initial latency, then serves linear
//   or wrapped read/write bursts from an internal 16-bit word array.
//   clk runs at 2x HyperBus CK. Each clk cycle with cs_n low is one DDR beat
//   (one byte).
//
// Ports
//   clk       system clock (2x CK)
//   rst_n     synchronous active-low reset; overrides cs_n
//   cs_n      chip select, active low
//   dq_in     DQ byte sampled from the master
//   dq_out    DQ byte driven by the slave (registered)
//   dq_oe     slave drives DQ (registered)
//   rwds_in   write byte mask from the master (1 = byte masked)
//   rwds_out  latency indication during CA, read strobe during data
//   rwds_oe   slave drives RWDS (registered)
//
// Optional feature macro: HB_CR0_REG_EN
//   When defined, this adds a writable CR0 register at register word address
//   bit0=1. CR0[3] then selects double or single latency.
//
// LATENCY must be at least 1.

module hyperbus_mem_slave #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned FIXED_2X   = 1,
  parameter int unsigned WRAP_WORDS = 16,
  parameter logic [15:0] ID0_VAL    = 16'h0C81
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic [7:0] dq_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  input  logic       rwds_in,
  output logic       rwds_out,
  output logic       rwds_oe
);

  localparam int unsigned   AW          = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] WRAP_MASK   = AW'(WRAP_WORDS - 1);
  localparam logic [15:0]   LAT_LAST_1X = 16'(2 * LATENCY - 1);
  localparam logic [15:0]   LAT_LAST_2X = 16'(4 * LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    WDATA,
    RDATA
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [39:0]   ca_q, ca_d;
  logic          is_read_q, is_read_d;
  logic          is_reg_q, is_reg_d;
  logic          is_lin_q, is_lin_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   lat_q, lat_d;
  // Read: the high byte is on the bus and the low byte comes next.
  // Write: the high byte has been captured and the low beat comes next.
  logic          half_q, half_d;
  logic [7:0]    wr_hi_q, wr_hi_d;
  logic          wr_hi_mask_q, wr_hi_mask_d;

  logic [7:0]    dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;
  logic          rwds_out_q, rwds_out_d;
  logic          rwds_oe_q, rwds_oe_d;

  logic          mem_we_hi, mem_we_lo;
  logic [15:0]   mem [MEM_WORDS];
  logic [15:0]   reg_word;
  logic [15:0]   rd_word;
  logic          mode2x;

`ifdef HB_CR0_REG_EN
  logic [15:0] cr0_q;
  logic        cr0_we_hi, cr0_we_lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cr0_q <= {12'h8F0, (FIXED_2X != 0), 3'b111};
    end else begin
      if (cr0_we_hi) cr0_q[15:8] <= wr_hi_q;
      if (cr0_we_lo) cr0_q[7:0]  <= dq_in;
    end
  end

  assign mode2x = cr0_q[3];
`else
  assign mode2x = (FIXED_2X != 0);
`endif

  // Linear bursts wrap at the array end. Wrapped bursts step only inside
  // their aligned group, starting from the CA address.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic lin);
    logic [AW-1:0] inc;
    inc = a + AW'(1);
    if (lin) next_addr = inc;
    else     next_addr = (a & ~WRAP_MASK) | (inc & WRAP_MASK);
  endfunction

  always_comb begin
`ifdef HB_CR0_REG_EN
    reg_word = addr_q[0] ? cr0_q : ID0_VAL;
`else
    reg_word = ID0_VAL;
`endif
    rd_word = is_reg_q ? reg_word : mem[addr_q];
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    ca_d         = ca_q;
    is_read_d    = is_read_q;
    is_reg_d     = is_reg_q;
    is_lin_d     = is_lin_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    half_d       = half_q;
    wr_hi_d      = wr_hi_q;
    wr_hi_mask_d = wr_hi_mask_q;
    dq_out_d     = '0;
    dq_oe_d      = 1'b0;
    rwds_out_d   = 1'b0;
    rwds_oe_d    = 1'b0;
    mem_we_hi    = 1'b0;
    mem_we_lo    = 1'b0;
`ifdef HB_CR0_REG_EN
    cr0_we_hi    = 1'b0;
    cr0_we_lo    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!cs_n) begin
          state_d    = CA;
          ca_d       = {ca_q[31:0], dq_in};
          beat_d     = 3'd1;
          rwds_oe_d  = 1'b1;
          rwds_out_d = mode2x;
        end
      end

      CA: begin
        if (cs_n) begin
          state_d = IDLE;
        end else if (beat_q == 3'd5) begin
          // {ca_q, dq_in} is the complete CA[47:0].
          is_read_d = ca_q[39];
          is_reg_d  = ca_q[38];
          is_lin_d  = ca_q[37];
          addr_d    = AW'({ca_q[36:8], dq_in[2:0]});
          lat_d     = '0;
          half_d    = 1'b0;
          state_d   = (!ca_q[39] && ca_q[38]) ? WDATA : LAT;
        end else begin
          ca_d       = {ca_q[31:0], dq_in};
          beat_d     = beat_q + 3'd1;
          rwds_oe_d  = 1'b1;
          rwds_out_d = mode2x;
        end
      end

      LAT: begin
        if (cs_n) begin
          state_d = IDLE;
        end else if (lat_q == (mode2x ? LAT_LAST_2X : LAT_LAST_1X)) begin
          half_d = 1'b0;
          if (is_read_q) begin
            state_d    = RDATA;
            dq_out_d   = rd_word[15:8];
            dq_oe_d    = 1'b1;
            rwds_oe_d  = 1'b1;
            rwds_out_d = 1'b1;
            half_d     = 1'b1;
          end else begin
            state_d = WDATA;
          end
        end else begin
          lat_d = lat_q + 16'd1;
        end
      end

      RDATA: begin
        if (cs_n) begin
          state_d = IDLE;
        end else begin
          dq_oe_d   = 1'b1;
          rwds_oe_d = 1'b1;
          if (half_q) begin
            dq_out_d   = rd_word[7:0];
            rwds_out_d = 1'b0;
            addr_d     = next_addr(addr_q, is_lin_q);
            half_d     = 1'b0;
          end else begin
            dq_out_d   = rd_word[15:8];
            rwds_out_d = 1'b1;
            half_d     = 1'b1;
          end
        end
      end

      WDATA: begin
        if (cs_n) begin
          // A pending high byte without its low byte is discarded.
          state_d = IDLE;
        end else if (!half_q) begin
          wr_hi_d      = dq_in;
          wr_hi_mask_d = rwds_in;
          half_d       = 1'b1;
        end else begin
          if (!is_reg_q) begin
            mem_we_hi = rst_n & ~wr_hi_mask_q;
            mem_we_lo = rst_n & ~rwds_in;
          end
`ifdef HB_CR0_REG_EN
          else if (addr_q[0]) begin
            cr0_we_hi = ~wr_hi_mask_q;
            cr0_we_lo = ~rwds_in;
          end
`endif
          addr_d = next_addr(addr_q, is_lin_q);
          half_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      ca_q         <= '0;
      is_read_q    <= 1'b0;
      is_reg_q     <= 1'b0;
      is_lin_q     <= 1'b0;
      addr_q       <= '0;
      lat_q        <= '0;
      half_q       <= 1'b0;
      wr_hi_q      <= '0;
      wr_hi_mask_q <= 1'b0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      rwds_out_q   <= 1'b0;
      rwds_oe_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      ca_q         <= ca_d;
      is_read_q    <= is_read_d;
      is_reg_q     <= is_reg_d;
      is_lin_q     <= is_lin_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      half_q       <= half_d;
      wr_hi_q      <= wr_hi_d;
      wr_hi_mask_q <= wr_hi_mask_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      rwds_out_q   <= rwds_out_d;
      rwds_oe_q    <= rwds_oe_d;
    end
  end

  // The memory array has no reset.
  always_ff @(posedge clk) begin
    if (mem_we_hi) mem[addr_q][15:8] <= wr_hi_q;
    if (mem_we_lo) mem[addr_q][7:0]  <= dq_in;
  end

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign rwds_out = rwds_out_q;
  assign rwds_oe  = rwds_oe_q;

endmodule
